// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Whole-line refill/eviction over a request/ack handshake with registered memory outputs.
module dcache_controller #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int WSEL_W = OFF_W - 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_MISS        = 3'd1;
    localparam logic [2:0] S_WRITEBACK   = 3'd2;
    localparam logic [2:0] S_REFILL      = 3'd3;
    localparam logic [2:0] S_REFILL_DONE = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    logic                 line_we;
    logic [TAG_W-1:0]     tag_d;
    logic [LINE_BITS-1:0] line_d;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [WSEL_W-1:0]    req_word;
    logic                 hit;
    logic                 unused_addr_lsb;

    assign req_idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign req_tag         = cpu_addr_i[31 -: TAG_W];
    assign req_word        = cpu_addr_i[OFF_W-1:2];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign hit = cpu_req_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                 && (state_q == S_IDLE);

    assign cpu_stall_o  = cpu_req_i && !hit;
    assign cpu_data_o   = (hit && !cpu_write_i) ? data_q[req_idx][req_word*32 +: 32] : 32'd0;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        line_we      = 1'b0;
        tag_d        = req_tag;
        line_d       = data_q[req_idx];

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i && !hit) begin
                    state_d = S_MISS;
                end else if (hit && cpu_write_i) begin
                    line_we                   = 1'b1;
                    line_d[req_word*32 +: 32] = cpu_data_i;
                    dirty_d[req_idx]          = 1'b1;
                end
            end
            S_MISS: begin
                mem_enable_d = 1'b1;
                if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    state_d     = S_WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
                    mem_data_d  = data_q[req_idx];
                end else begin
                    state_d     = S_REFILL;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
                    mem_data_d  = '0;
                end
            end
            S_WRITEBACK: begin
                // Refill request follows the writeback ack with no idle gap.
                if (mem_ack_i) begin
                    state_d      = S_REFILL;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {req_tag, req_idx, {OFF_W{1'b0}}};
                    mem_data_d   = '0;
                end
            end
            S_REFILL: begin
                if (mem_ack_i) begin
                    state_d          = S_REFILL_DONE;
                    line_we          = 1'b1;
                    line_d           = mem_data_i;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    mem_enable_d     = 1'b0;
                    mem_write_d      = 1'b0;
                    mem_addr_d       = '0;
                    mem_data_d       = '0;
                end
            end
            S_REFILL_DONE: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[req_idx]  <= tag_d;
            data_q[req_idx] <= line_d;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: vector table for hit streams,
// hand-written miss/eviction/reset sequences, and a memory-transaction scoreboard.
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i, model_ack, stray_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;
    txn_t exp_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_stall;
    } vec_t;
    vec_t vecs[11];

    int mem_delay = 3;
    bit mem_hold  = 1'b0;
    int mem_cnt   = 0;

    assign mem_ack_i = model_ack | stray_ack;

    dcache_controller #(.NUM_LINES(16), .LINE_BITS(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++)
            l[k*32 +: 32] = (a == 32'h100) ? 32'h11 * (k + 1) : (a ^ 32'h5A00_0000) + k;
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [255:0] l;
        l = line_of({a[31:5], 5'b0});
        return l[a[4:2]*32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic push_txn(input logic wr, input logic [31:0] addr, input logic [255:0] data);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data;
        exp_q.push_back(t);
    endtask

    // Memory model: logs each request on its first cycle, acks after mem_delay cycles.
    initial begin
        txn_t t;
        model_ack  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            model_ack = 1'b0;
            if (rst_i || !mem_enable_o) begin
                mem_cnt = 0;
            end else begin
                mem_cnt++;
                if (mem_cnt == 1) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_txn unexpected wr=%0b addr=%h", mem_write_o, mem_addr_o);
                    end else begin
                        t = exp_q.pop_front();
                        chk("mem_write", 256'(mem_write_o), 256'(t.wr));
                        chk("mem_addr", 256'(mem_addr_o), 256'(t.addr));
                        if (t.wr) chk("mem_wdata", mem_data_o, t.data);
                    end
                end
                if (!mem_hold && mem_cnt >= mem_delay) begin
                    model_ack  = 1'b1;
                    mem_data_i = line_of(mem_addr_o);
                    mem_cnt    = 0;
                end
            end
        end
    end

    task automatic access(input string nm, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input int exp_stall);
        int n;
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = wdata;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL %s_timeout stall still high after %0d cycles", nm, n);
                break;
            end
            @(posedge clk_i); #1;
        end
        chk({nm, "_data"}, 256'(cpu_data_o), 256'(exp_data));
        chk({nm, "_stall_cycles"}, 256'(n), 256'(exp_stall));
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] evict;
        int n;

        vecs[0]  = '{1'b0, 32'h500, 32'h0, word_of(32'h500), 1'b0};
        vecs[1]  = '{1'b0, 32'h504, 32'h0, word_of(32'h504), 1'b0};
        vecs[2]  = '{1'b0, 32'h508, 32'h0, word_of(32'h508), 1'b0};
        vecs[3]  = '{1'b0, 32'h50C, 32'h0, word_of(32'h50C), 1'b0};
        vecs[4]  = '{1'b0, 32'h510, 32'h0, word_of(32'h510), 1'b0};
        vecs[5]  = '{1'b0, 32'h514, 32'h0, word_of(32'h514), 1'b0};
        vecs[6]  = '{1'b0, 32'h518, 32'h0, word_of(32'h518), 1'b0};
        vecs[7]  = '{1'b0, 32'h51C, 32'h0, word_of(32'h51C), 1'b0};
        vecs[8]  = '{1'b1, 32'h50C, 32'hCAFE_0001, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h50C, 32'h0, 32'hCAFE_0001, 1'b0};
        vecs[10] = '{1'b0, 32'h44, 32'h0, 32'h1234_5678, 1'b0};

        rst_i = 1'b1; stray_ack = 1'b0;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h104; cpu_data_i = '0;
        @(posedge clk_i); #1;
        chk("rst_stall", 256'(cpu_stall_o), 256'(1));
        chk("rst_cpu_data", 256'(cpu_data_o), 256'(0));
        chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_data", mem_data_o, 256'(0));
        cpu_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Cold load, ack on the third request cycle: T, MISS, 3x REFILL, REFILL_DONE.
        push_txn(1'b0, 32'h100, '0);
        access("cold_load", 1'b0, 32'h104, 32'h0, 32'h22, 6);

        access("store_hit", 1'b1, 32'h108, 32'hDEAD_BEEF, 32'h0, 0);
        access("reload_108", 1'b0, 32'h108, 32'h0, 32'hDEAD_BEEF, 0);

        evict = line_of(32'h100);
        evict[2*32 +: 32] = 32'hDEAD_BEEF;
        push_txn(1'b1, 32'h100, evict);
        push_txn(1'b0, 32'h300, '0);
        access("dirty_evict", 1'b0, 32'h304, 32'h0, word_of(32'h304), 9);

        push_txn(1'b0, 32'h500, '0);
        access("clean_replace", 1'b0, 32'h500, 32'h0, word_of(32'h500), 6);

        // Store miss with ack in the first request cycle: minimum 4-cycle stall.
        mem_delay = 1;
        push_txn(1'b0, 32'h40, '0);
        access("store_miss", 1'b1, 32'h44, 32'h1234_5678, 32'h0, 4);
        mem_delay = 3;

        @(posedge clk_i); #1;
        foreach (vecs[i]) begin
            cpu_req_i = 1'b1; cpu_write_i = vecs[i].wr;
            cpu_addr_i = vecs[i].addr; cpu_data_i = vecs[i].wdata;
            @(negedge clk_i);
            chk($sformatf("vec%0d_stall", i), 256'(cpu_stall_o), 256'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_data", i), 256'(cpu_data_o), 256'(vecs[i].exp_data));
            @(posedge clk_i); #1;
        end
        cpu_req_i = 1'b0; cpu_write_i = 1'b0;

        // Reset while a refill is outstanding.
        mem_hold = 1'b1;
        push_txn(1'b0, 32'h600, '0);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_addr_i = 32'h600;
        n = 0;
        while (!mem_enable_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("midrst_enable_seen", 256'(mem_enable_o), 256'(1));
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        chk("midrst_enable_async", 256'(mem_enable_o), 256'(0));
        chk("midrst_addr_async", 256'(mem_addr_o), 256'(0));
        chk("midrst_stall", 256'(cpu_stall_o), 256'(1));
        cpu_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0; mem_hold = 1'b0;
        stray_ack = 1'b1;
        @(posedge clk_i); #1;
        stray_ack = 1'b0;
        @(negedge clk_i);
        chk("stray_ack_enable", 256'(mem_enable_o), 256'(0));
        chk("stray_ack_stall", 256'(cpu_stall_o), 256'(0));
        push_txn(1'b0, 32'h600, '0);
        access("post_rst_load", 1'b0, 32'h604, 32'h0, word_of(32'h604), 6);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache for the MEM stage of the 5-stage pipeline. It serves CPU loads and stores from on-chip line storage and fetches or evicts whole 256-bit lines from data memory through a request/acknowledge handshake. Load data feeds the MEM/WB pipeline register. `cpu_stall_o` freezes every pipeline register while a miss is outstanding.

## Interface
- `NUM_LINES`, 16: number of cache lines; power of two.
- `LINE_BITS`, 256: line width; 8 words of 32 bits.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cpu_req_i` in 1: CPU access valid this cycle.
- `cpu_write_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address; word aligned.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data.
- `cpu_stall_o` out 1: pipeline must hold.
- `mem_enable_o` out 1: memory request valid.
- `mem_write_o` out 1: 1 = line write, 0 = line read.
- `mem_addr_o` out 32: line-aligned memory address.
- `mem_data_o` out 256: evicted line.
- `mem_data_i` in 256: refill line.
- `mem_ack_i` in 1: one-cycle completion pulse from memory.

## Operation
- **Address split (`NUM_LINES`=16):**
  - offset = `addr[4:0]`; word select = `addr[4:2]`.
  - index = `addr[8:5]`; tag = `addr[31:9]`.
  - Field widths scale with `log2(NUM_LINES)`.
- **Per-line state:** valid bit, dirty bit, tag, 256-bit data. Word k occupies bits `[32k+31:32k]`.
- **hit** = `cpu_req_i` & valid[index] & (tag[index] == tag) & state==IDLE. Combinational.
- **`cpu_data_o`:** the selected word on a load hit; 0 otherwise.
- **`cpu_stall_o`:** `cpu_req_i & ~hit`. Combinational.
- **Load hit:** no state change.
- **Store hit:** at the clock edge, write `cpu_data_i` into the selected word and set dirty[index]=1.
- **FSM states:** IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
  - **IDLE:** if `cpu_req_i` & ~hit, go to MISS. Otherwise stay.
  - **MISS:** if valid & dirty, go to WRITEBACK. Otherwise go to REFILL. Stays one cycle.
  - **WRITEBACK:**
    - Drive `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o` = {stored tag, index, 5'b0}, `mem_data_o` = stored line.
    - Hold until `mem_ack_i`=1 is sampled, then go to REFILL.
  - **REFILL:**
    - Drive `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o` = {request tag, index, 5'b0}.
    - On the edge where `mem_ack_i`=1: load `mem_data_i` into the line, set valid=1 and dirty=0, write the new tag, then go to REFILL_DONE.
  - **REFILL_DONE:** go to IDLE. The held request now hits. A store then updates the word and sets dirty.
- `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are registered. They stay stable for the whole request and drop to 0 the cycle after the ack.
- `mem_ack_i` is ignored outside WRITEBACK and REFILL.
- **CPU contract:** the CPU holds `cpu_req_i`, `cpu_write_i`, `cpu_addr_i` and `cpu_data_i` stable while `cpu_stall_o`=1.

## Timing
- **Reset:** state=IDLE; all valid and dirty bits 0; `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0. Tags and data are not reset.
  - Since hit can't be 1 with all valid bits 0, `cpu_data_o`=0 and `cpu_stall_o`=`cpu_req_i`.
- **Hit latency:** 0 cycles. Data is valid in the same cycle as the request; store data commits at the next edge.
- **Clean miss:** stall from request cycle T. MISS at T+1, REFILL at T+2. If the ack is sampled at edge A: REFILL_DONE at A+1, IDLE/hit at A+2, and stall is 0 from A+2.
- **Dirty miss:** adds WRITEBACK between MISS and REFILL. The refill request starts the cycle after the writeback ack.
- **Ack in the first request cycle:** legal. Minimum clean-miss stall is 4 cycles (T to T+3 inclusive).
- **Reset mid-miss:** abandon the transaction and return to IDLE. The line being refilled stays invalid. `mem_enable_o` drops asynchronously.
- **Edge cases:**
  - Request while not in IDLE: treated as a stall continuation, never a new access.
  - Index conflict with a different tag on a valid clean line: replaced with no writeback.

## Test plan
- **Cold load:** reset, then load 0x0000_0104 with memory returning line words W0..W7 = 0x11..0x88, ack 3 cycles after enable.
  - Exactly one read at `mem_addr_o`=0x0000_0100.
  - `cpu_data_o`=0x22 with stall=0 at A+2.
  - Stall high from T through A+1.
- **Store hit:** after the cold load, store 0xDEAD_BEEF to 0x0000_0108.
  - No stall and no memory traffic.
  - A reload of 0x108 returns 0xDEAD_BEEF.
- **Dirty eviction:** then load 0x0000_0304 (same index 8, new tag).
  - Write at 0x0000_0100 with word 2 = 0xDEAD_BEEF, then read at 0x0000_0300.
  - Load returns the new line's word 1.
- **Clean replacement:** load 0x0000_0500 after the eviction. Line is clean, so read only and no write.
- **Reset mid-refill:** assert `rst_i` while in REFILL, before the ack.
  - `mem_enable_o`=0 immediately.
  - A stray ack afterwards is ignored.
  - The next load to the same address misses again.
- **Back-to-back hits:** 8 consecutive loads of one resident line. No stall, one word per cycle, correct values.
